// File: rtl/wr_resp_direction_queue.sv
// -----------------------------------------------------------------------------
// wr_resp_direction_queue
//
// Purpose:
//   Takes the write-request stream through a valid/ready handshake and steers
//   every write into one of WIDTH per-direction response FIFOs. The FIFO is
//   chosen by cmd_txnid.direction_id. Each direction drains independently
//   through its own valid/ready port. Reads, and writes whose direction is out
//   of range, are consumed and dropped. An out-of-range write also sets the
//   sticky err_dir flag.
//
// Ports:
//   clk          in   single clock, rising-edge
//   rst          in   synchronous active-high reset
//   req_vld      in   request valid
//   req_rdy      out  request ready (low only for a write to a full FIFO)
//   req_pld      in   request payload (opcode, txnid, sideband)
//   v_wresp_vld  out  per-direction response valid (FIFO not empty)
//   v_wresp_rdy  in   per-direction response ready (pops the head)
//   v_wresp_pld  out  per-direction head entry {txnid, sideband}
//   v_fifo_cnt   out  per-direction occupancy
//   err_dir      out  sticky: a write was accepted with direction_id >= WIDTH
// -----------------------------------------------------------------------------
package wr_resp_direction_queue_pkg;

  // direction_id is sized for up to four directions. With WIDTH == 4 every
  // encoding is valid. With WIDTH == 3 the value 3 is the out-of-range case.
  localparam int DIR_W = 2;
  localparam int TAG_W = 8;
  localparam int SB_W  = 4;

  localparam logic OPC_WRITE = 1'b0;
  localparam logic OPC_READ  = 1'b1;

  typedef struct packed {
    logic [DIR_W-1:0] direction_id;
    logic [TAG_W-1:0] tag;
  } txnid_t;

  typedef struct packed {
    logic             cmd_opcode;
    txnid_t           cmd_txnid;
    logic [SB_W-1:0]  cmd_sideband;
  } input_req_pld_t;

  typedef struct packed {
    txnid_t           txnid;
    logic [SB_W-1:0]  sideband;
  } wr_resp_pld_t;

endpackage

module wr_resp_direction_queue
  import wr_resp_direction_queue_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_vld,
  output logic                            req_rdy,
  input  input_req_pld_t                  req_pld,
  output logic         [WIDTH-1:0]        v_wresp_vld,
  input  logic         [WIDTH-1:0]        v_wresp_rdy,
  output wr_resp_pld_t [WIDTH-1:0]        v_wresp_pld,
  output logic         [WIDTH-1:0][CNT_W-1:0] v_fifo_cnt,
  output logic                            err_dir
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Request decode
  logic [DIR_W-1:0] w_dir;
  logic             w_is_wr;
  logic             w_in_range;
  logic             w_xfer;
  logic [WIDTH-1:0] w_hit;
  logic [WIDTH-1:0] w_full;
  logic [WIDTH-1:0] w_push;
  logic [WIDTH-1:0] w_pop;

  // FIFO state
  logic [PTR_W-1:0] r_wptr [WIDTH];
  logic [PTR_W-1:0] r_rptr [WIDTH];
  logic [CNT_W-1:0] r_cnt  [WIDTH];
  wr_resp_pld_t     r_mem  [WIDTH][DEPTH];
  logic             r_err;

  assign w_dir   = req_pld.cmd_txnid.direction_id;
  assign w_is_wr = (req_pld.cmd_opcode == OPC_WRITE);

  // When WIDTH covers every direction_id encoding, no write can be out of range.
  generate
    if (WIDTH >= (1 << DIR_W)) begin : g_dir_full_range
      assign w_in_range = 1'b1;
    end else begin : g_dir_part_range
      assign w_in_range = (w_dir < DIR_W'(WIDTH));
    end
  endgenerate

  always_comb begin
    w_hit  = '0;
    w_full = '0;
    w_pop  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_hit[i]  = w_is_wr && (w_dir == DIR_W'(i));
      w_full[i] = (r_cnt[i] == FULL_CNT);
      // Pop uses registered vld, so v_wresp_rdy never reaches an output combinationally.
      w_pop[i]  = (r_cnt[i] != '0) && v_wresp_rdy[i];
    end
  end

  // Only a write whose own FIFO is full stalls the stream. A pop in the same
  // cycle does not free the slot early, which keeps v_wresp_rdy off this path.
  assign req_rdy = ~|(w_hit & w_full);
  assign w_xfer  = req_vld && req_rdy;

  // A transfer presented during reset is ignored, including its storage write.
  assign w_push = (w_xfer && !rst) ? w_hit : '0;

  // Storage is not reset. Its contents are don't-care while the count is zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wptr[i]] <= wr_resp_pld_t'{txnid:    req_pld.cmd_txnid,
                                              sideband: req_pld.cmd_sideband};
      end
    end
  end

  // Pointers wrap naturally, because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_push[i]) begin
          r_wptr[i] <= r_wptr[i] + PTR_W'(1);
        end
        if (w_pop[i]) begin
          r_rptr[i] <= r_rptr[i] + PTR_W'(1);
        end
        case ({w_push[i], w_pop[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - CNT_W'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
      if (w_xfer && w_is_wr && !w_in_range) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    v_wresp_vld = '0;
    v_wresp_pld = '0;
    v_fifo_cnt  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      v_wresp_vld[i] = (r_cnt[i] != '0);
      v_wresp_pld[i] = r_mem[i][r_rptr[i]];
      v_fifo_cnt[i]  = r_cnt[i];
    end
  end

  assign err_dir = r_err;

endmodule

// File: tb/tb_wr_resp_direction_queue.sv
// -----------------------------------------------------------------------------
// tb_wr_resp_direction_queue
//
// Drives a WIDTH=4/DEPTH=4 instance through directed and randomized steps.
// Every cycle is checked against a queue-per-direction reference model.
// A WIDTH=3 instance covers the out-of-range direction and the sticky error.
// -----------------------------------------------------------------------------
module tb_wr_resp_direction_queue;
  import wr_resp_direction_queue_pkg::*;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic                       rst;
  logic                       req_vld;
  logic                       req_rdy;
  input_req_pld_t             req_pld;
  logic         [W-1:0]       v_wresp_vld;
  logic         [W-1:0]       v_wresp_rdy;
  wr_resp_pld_t [W-1:0]       v_wresp_pld;
  logic         [W-1:0][CW-1:0] v_fifo_cnt;
  logic                       err_dir;

  // Three-direction instance
  logic                       rst3;
  logic                       req_vld3;
  logic                       req_rdy3;
  input_req_pld_t             req_pld3;
  logic         [2:0]         vld3;
  logic         [2:0]         rdy3;
  wr_resp_pld_t [2:0]         pld3;
  logic         [2:0][CW-1:0] cnt3;
  logic                       err3;

  wr_resp_direction_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_pld(req_pld),
    .v_wresp_vld(v_wresp_vld), .v_wresp_rdy(v_wresp_rdy),
    .v_wresp_pld(v_wresp_pld), .v_fifo_cnt(v_fifo_cnt),
    .err_dir(err_dir)
  );

  wr_resp_direction_queue #(.WIDTH(3), .DEPTH(D)) dut3 (
    .clk(clk), .rst(rst3),
    .req_vld(req_vld3), .req_rdy(req_rdy3), .req_pld(req_pld3),
    .v_wresp_vld(vld3), .v_wresp_rdy(rdy3),
    .v_wresp_pld(pld3), .v_fifo_cnt(cnt3),
    .err_dir(err3)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one queue of expected responses per direction.
  wr_resp_pld_t mq [W][$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic op, input int dir,
                       input int tag, input int sb);
    req_vld                           = vld;
    req_pld.cmd_opcode                = op;
    req_pld.cmd_txnid.direction_id    = DIR_W'(dir);
    req_pld.cmd_txnid.tag             = TAG_W'(tag);
    req_pld.cmd_sideband              = SB_W'(sb);
  endtask

  task automatic drive3(input logic vld, input int dir, input int tag);
    req_vld3                        = vld;
    req_pld3.cmd_opcode             = OPC_WRITE;
    req_pld3.cmd_txnid.direction_id = DIR_W'(dir);
    req_pld3.cmd_txnid.tag          = TAG_W'(tag);
    req_pld3.cmd_sideband           = SB_W'(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the current outputs against the model, lets one clock edge pass,
  // then advances the model by what that edge should have done.
  task automatic cycle();
    logic         exp_rdy;
    logic         push;
    logic [W-1:0] pop;
    int           d;
    wr_resp_pld_t ent;
    #1;
    d       = int'(req_pld.cmd_txnid.direction_id);
    exp_rdy = !(req_pld.cmd_opcode == OPC_WRITE && mq[d].size() >= D);
    chk("req_rdy", 32'(req_rdy), 32'(exp_rdy));
    for (int i = 0; i < W; i++) begin
      chk($sformatf("vld%0d", i), 32'(v_wresp_vld[i]), 32'(mq[i].size() != 0));
      chk($sformatf("cnt%0d", i), 32'(v_fifo_cnt[i]), 32'(mq[i].size()));
      if (mq[i].size() != 0)
        chk($sformatf("pld%0d", i), 32'(v_wresp_pld[i]), 32'(mq[i][0]));
    end
    chk("err_dir", 32'(err_dir), 32'(0));
    push = !rst && req_vld && exp_rdy && (req_pld.cmd_opcode == OPC_WRITE);
    ent  = '{txnid: req_pld.cmd_txnid, sideband: req_pld.cmd_sideband};
    for (int i = 0; i < W; i++)
      pop[i] = !rst && (mq[i].size() != 0) && v_wresp_rdy[i];
    tick();
    if (rst) begin
      for (int i = 0; i < W; i++) mq[i].delete();
    end else begin
      for (int i = 0; i < W; i++)
        if (pop[i]) void'(mq[i].pop_front());
      if (push) mq[d].push_back(ent);
    end
  endtask

  initial begin
    rst = 1'b1;
    rst3 = 1'b1;
    drive(1'b0, OPC_READ, 0, 0, 0);
    drive3(1'b0, 0, 0);
    v_wresp_rdy = '0;
    rdy3 = '0;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;

    // Reset state
    chk("rst_rdy", 32'(req_rdy), 32'(1));
    chk("rst_vld", 32'(v_wresp_vld), 32'(0));
    chk("rst_cnt", 32'(v_fifo_cnt), 32'(0));
    chk("rst_err", 32'(err_dir), 32'(0));

    // A single write to direction 2, visible one cycle later, then popped
    drive(1'b1, OPC_WRITE, 2, 'h16, 'h5);
    cycle();
    drive(1'b0, OPC_WRITE, 0, 0, 0);
    chk("w2_vld", 32'(v_wresp_vld), 32'(4'b0100));
    chk("w2_txnid", 32'(v_wresp_pld[2].txnid.tag), 32'('h16));
    chk("w2_sb", 32'(v_wresp_pld[2].sideband), 32'('h5));
    chk("w2_cnt", 32'(v_fifo_cnt[2]), 32'(1));
    v_wresp_rdy = 4'b0100;
    cycle();
    chk("w2_pop_vld", 32'(v_wresp_vld), 32'(0));
    v_wresp_rdy = '0;

    // Reads are consumed and dropped
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, OPC_READ, k % 4, 'h30 + k, k);
      chk("rd_rdy", 32'(req_rdy), 32'(1));
      cycle();
    end
    chk("rd_vld", 32'(v_wresp_vld), 32'(0));
    chk("rd_cnt", 32'(v_fifo_cnt), 32'(0));

    // Fill direction 1. The fifth write stalls until the first pop.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, OPC_WRITE, 1, 'h40 + k, k);
      cycle();
    end
    drive(1'b1, OPC_WRITE, 1, 'h44, 4);
    #1;
    chk("full1_rdy", 32'(req_rdy), 32'(0));
    cycle();
    v_wresp_rdy = 4'b0010;
    cycle();
    chk("reen1_rdy", 32'(req_rdy), 32'(1));
    cycle();
    drive(1'b0, OPC_WRITE, 0, 0, 0);
    for (int k = 0; k < 6; k++) cycle();
    v_wresp_rdy = '0;

    // Full direction 0 with a pop in the same cycle: the push still stalls.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, OPC_WRITE, 0, 'h50 + k, k);
      cycle();
    end
    drive(1'b1, OPC_WRITE, 0, 'h54, 4);
    v_wresp_rdy = 4'b0001;
    cycle();
    chk("bp_cnt3", 32'(v_fifo_cnt[0]), 32'(3));
    v_wresp_rdy = '0;
    cycle();
    chk("bp_cnt4", 32'(v_fifo_cnt[0]), 32'(4));
    // Stream 3*DEPTH entries through direction 0 so the pointers wrap.
    v_wresp_rdy = 4'b0001;
    for (int k = 0; k < 3 * D; k++) begin
      drive(1'b1, OPC_WRITE, 0, 'h60 + k, k);
      cycle();
    end
    drive(1'b0, OPC_WRITE, 0, 0, 0);
    for (int k = 0; k < D + 2; k++) cycle();
    chk("wrap_cnt", 32'(v_fifo_cnt[0]), 32'(0));

    // Interleaved writes to directions 0 and 3 with random ready
    for (int k = 0; k < 200; k++) begin
      drive(1'($urandom_range(0, 3) != 0), OPC_WRITE,
            ($urandom_range(0, 1) != 0) ? 3 : 0, k, int'($urandom));
      v_wresp_rdy = {1'($urandom), 2'b00, 1'($urandom)};
      cycle();
    end

    // Fully random opcode, direction and ready
    for (int k = 0; k < 200; k++) begin
      drive(1'($urandom), 1'($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 3)), int'($urandom), int'($urandom));
      v_wresp_rdy = 4'($urandom);
      cycle();
    end

    // Reset mid-stream discards everything queued.
    v_wresp_rdy = '0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, OPC_WRITE, (k % 2 != 0) ? 3 : 0, 'h90 + k, k);
      cycle();
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mrst_vld", 32'(v_wresp_vld), 32'(0));
    chk("mrst_cnt", 32'(v_fifo_cnt), 32'(0));
    drive(1'b1, OPC_WRITE, 3, 'hA0, 1);
    cycle();
    drive(1'b0, OPC_WRITE, 0, 0, 0);
    cycle();

    // Three-direction instance: direction 3 is out of range.
    v_wresp_rdy = '0;
    rst3 = 1'b0;
    drive3(1'b1, 3, 'h33);
    #1;
    chk("d3_rdy", 32'(req_rdy3), 32'(1));
    tick();
    drive3(1'b0, 0, 0);
    chk("d3_vld", 32'(vld3), 32'(0));
    chk("d3_cnt", 32'(cnt3), 32'(0));
    chk("d3_err", 32'(err3), 32'(1));
    repeat (3) tick();
    chk("d3_err_hold", 32'(err3), 32'(1));
    drive3(1'b1, 0, 'h21);
    tick();
    drive3(1'b0, 0, 0);
    chk("d3_ok_vld", 32'(vld3), 32'(3'b001));
    chk("d3_ok_tag", 32'(pld3[0].txnid.tag), 32'('h21));
    chk("d3_ok_err", 32'(err3), 32'(1));
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    chk("d3_rst_err", 32'(err3), 32'(0));
    chk("d3_rst_vld", 32'(vld3), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
